// File: rtl/mdu_if.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_if
//  Description : Bundle between the execute stage and the multiply/divide
//                unit. The master (datapath/control) drives the operands,
//                the opcode and start; the slave (mdu) returns busy and the
//                architectural HI/LO registers.
//    num1  [31:0]  rs operand (dividend / multiplicand / mthi-mtlo source)
//    num2  [31:0]  rt operand (divisor / multiplier)
//    op    [2:0]   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
//    start         qualifies op for one cycle
//    busy          a mult/div is in flight
//    hi    [31:0]  architectural HI register
//    lo    [31:0]  architectural LO register
//  Revision    : 1.0 - initial release
// ============================================================================
interface mdu_if;
    logic [31:0] num1;
    logic [31:0] num2;
    logic [2:0]  op;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output num1, num2, op, start,
        input  busy, hi, lo
    );

    modport slave (
        input  num1, num2, op, start,
        output busy, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
//  Module      : mdu
//  Description : Multi-cycle MIPS multiply/divide unit with architectural
//                HI/LO registers. mult/multu/div/divu hold busy for a fixed
//                number of cycles and then commit HI/LO in one edge;
//                mthi/mtlo write directly with no busy cycle.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - mdu_if.slave (num1, num2, op, start, busy, hi, lo)
//  Parameters  : MULT_CYCLES - busy cycles for mult/multu (>= 1)
//                DIV_CYCLES  - busy cycles for div/divu  (>= 1)
//  Macro       : MDU_DIV_EN  - when defined, div/divu are implemented;
//                otherwise op 3/4 act as no-ops and no divider is built.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic clk,
    input  wire logic rst,
    mdu_if.slave      bus
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    // Counter only ever holds N-1, so clog2(max N) bits suffice.
    localparam int c_CNT_W = (c_MAX_CYCLES > 1) ? $clog2(c_MAX_CYCLES) : 1;

    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES - 1);

    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;

    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_res_hi;
    logic [31:0]        r_res_lo;
    // Cleared for a zero divisor so the commit edge leaves HI/LO untouched.
    logic               r_res_wr;

    // ------------------------------------------------------------------------
    // Multiplier: both products are taken on 64-bit extended operands; the
    // low 64 bits of the extended product are the exact signed/unsigned
    // result, so no signed arithmetic types are needed.
    // ------------------------------------------------------------------------
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;

    assign w_prod_s = {{32{bus.num1[31]}}, bus.num1} * {{32{bus.num2[31]}}, bus.num2};
    assign w_prod_u = {32'd0, bus.num1} * {32'd0, bus.num2};

`ifdef MDU_DIV_EN
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD = c_CNT_W'(DIV_CYCLES - 1);
    localparam logic [2:0] c_OP_DIV  = 3'd3;
    localparam logic [2:0] c_OP_DIVU = 3'd4;

    // ------------------------------------------------------------------------
    // Divider: signed division runs on magnitudes, then the quotient takes
    // the XOR of the operand signs and the remainder the dividend's sign.
    // 0x80000000 / -1 falls out naturally: |a| = 2^31, negated back to
    // 0x80000000 with remainder 0.
    // ------------------------------------------------------------------------
    logic        w_signed;
    logic        w_neg_a;
    logic        w_neg_b;
    logic        w_div_zero;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_dvsr;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_signed   = (bus.op == c_OP_DIV);
    assign w_neg_a    = w_signed & bus.num1[31];
    assign w_neg_b    = w_signed & bus.num2[31];
    assign w_div_zero = (bus.num2 == 32'd0);
    assign w_abs_a    = w_neg_a ? (32'd0 - bus.num1) : bus.num1;
    assign w_abs_b    = w_neg_b ? (32'd0 - bus.num2) : bus.num2;
    // Substitute a divisor of 1 so a zero divisor never produces X; the
    // result is discarded anyway.
    assign w_dvsr     = w_div_zero ? 32'd1 : w_abs_b;
    assign w_q_mag    = w_abs_a / w_dvsr;
    assign w_r_mag    = w_abs_a % w_dvsr;
    assign w_quot     = (w_neg_a ^ w_neg_b) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem      = w_neg_a ? (32'd0 - w_r_mag) : w_r_mag;
`endif

    // ------------------------------------------------------------------------
    // Control. The result is computed and captured when the op is accepted,
    // so operand changes during BUSY cannot affect it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
            r_res_wr <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            c_OP_MULT: begin
                                r_res_hi <= w_prod_s[63:32];
                                r_res_lo <= w_prod_s[31:0];
                                r_res_wr <= 1'b1;
                                r_cnt    <= c_MULT_LOAD;
                                r_state  <= c_ST_BUSY;
                            end
                            c_OP_MULTU: begin
                                r_res_hi <= w_prod_u[63:32];
                                r_res_lo <= w_prod_u[31:0];
                                r_res_wr <= 1'b1;
                                r_cnt    <= c_MULT_LOAD;
                                r_state  <= c_ST_BUSY;
                            end
`ifdef MDU_DIV_EN
                            c_OP_DIV, c_OP_DIVU: begin
                                r_res_hi <= w_rem;
                                r_res_lo <= w_quot;
                                r_res_wr <= ~w_div_zero;
                                r_cnt    <= c_DIV_LOAD;
                                r_state  <= c_ST_BUSY;
                            end
`endif
                            c_OP_MTHI: r_hi <= bus.num1;
                            c_OP_MTLO: r_lo <= bus.num1;
                            default: ;
                        endcase
                    end
                end
                c_ST_BUSY: begin
                    // start is deliberately ignored here, mthi/mtlo included.
                    if (r_cnt == '0) begin
                        if (r_res_wr) begin
                            r_hi <= r_res_hi;
                            r_lo <= r_res_lo;
                        end
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign bus.busy = (r_state == c_ST_BUSY);
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu
//  Description : Self-checking bench for mdu. Directed cases plus random
//                ops are compared against a reference model that computes
//                HI/LO with plain 64-bit arithmetic and knows the expected
//                number of busy cycles per op. Divide expectations follow
//                the MDU_DIV_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
`ifdef MDU_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    typedef longint unsigned u64_t;

    logic clk = 1'b0;
    logic rst;

    mdu_if bus ();

    mdu #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] m_hi    = 32'd0;
    logic [31:0] m_lo    = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural effect of one accepted op; returns the busy length.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int n);
        longint sp;
        u64_t   up;
        longint sa;
        longint sb;
        n = 0;
        case (op)
            3'd1: begin
                sp   = longint'($signed(a)) * longint'($signed(b));
                m_hi = sp[63:32];
                m_lo = sp[31:0];
                n    = MULT_N;
            end
            3'd2: begin
                up   = u64_t'(a) * u64_t'(b);
                m_hi = up[63:32];
                m_lo = up[31:0];
                n    = MULT_N;
            end
            3'd3: if (DIV_ON) begin
                n = DIV_N;
                if (b != 32'd0) begin
                    sa   = longint'($signed(a));
                    sb   = longint'($signed(b));
                    m_lo = 32'(sa / sb);
                    m_hi = 32'(sa % sb);
                end
            end
            3'd4: if (DIV_ON) begin
                n = DIV_N;
                if (b != 32'd0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue one op, optionally poke start during busy, count busy cycles and
    // check HI/LO hold during busy and the committed values afterwards.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit interfere, input string tag);
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        int          n;
        int          cnt;
        pre_hi = m_hi;
        pre_lo = m_lo;
        model(op, a, b, n);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.num1  = a;
        bus.num2  = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.num1  = $urandom;
        bus.num2  = $urandom;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 200) begin
            if (cnt == 0) begin
                check({tag, " hold_hi"}, bus.hi, pre_hi);
                check({tag, " hold_lo"}, bus.lo, pre_lo);
            end
            if (interfere && cnt == 0) begin
                bus.start = 1'b1;
                bus.op    = 3'd6;
                bus.num1  = $urandom;
            end
            if (interfere && cnt == 1) begin
                bus.op   = 3'd1;
                bus.num1 = $urandom;
                bus.num2 = $urandom;
            end
            if (interfere && cnt == 2) bus.start = 1'b0;
            cnt++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check({tag, " busy_cycles"}, 32'(cnt), 32'(n));
        check({tag, " hi"}, bus.hi, m_hi);
        check({tag, " lo"}, bus.lo, m_lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        n_bad++;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.num1  = 32'd0;
        bus.num2  = 32'd0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        rst = 1'b0;

        run_op(3'd0, 32'hDEADBEEF, 32'h1234, 1'b0, "nop");
        run_op(3'd7, 32'hCAFEF00D, 32'h5, 1'b0, "reserved");

        run_op(3'd1, 32'hFFFFFFFF, 32'h2, 1'b0, "mult");
        check("mult const hi", bus.hi, 32'hFFFFFFFF);
        check("mult const lo", bus.lo, 32'hFFFFFFFE);
        run_op(3'd2, 32'hFFFFFFFF, 32'h2, 1'b0, "multu");
        check("multu const hi", bus.hi, 32'h00000001);
        check("multu const lo", bus.lo, 32'hFFFFFFFE);

        run_op(3'd3, 32'hFFFFFFF9, 32'h2, 1'b0, "div_neg7");
`ifdef MDU_DIV_EN
        check("div const lo", bus.lo, 32'hFFFFFFFD);
        check("div const hi", bus.hi, 32'hFFFFFFFF);
`endif
        run_op(3'd4, 32'd7, 32'd2, 1'b0, "divu_7_2");
`ifdef MDU_DIV_EN
        check("divu const lo", bus.lo, 32'd3);
        check("divu const hi", bus.hi, 32'd1);
`endif
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf");
`ifdef MDU_DIV_EN
        check("div_ovf const lo", bus.lo, 32'h80000000);
        check("div_ovf const hi", bus.hi, 32'd0);
`endif

        run_op(3'd5, 32'h11, 32'h0, 1'b0, "mthi_pre");
        run_op(3'd6, 32'h22, 32'h0, 1'b0, "mtlo_pre");
        run_op(3'd4, 32'h9999, 32'h0, 1'b0, "divu_zero");
        check("divzero const hi", bus.hi, 32'h11);
        check("divzero const lo", bus.lo, 32'h22);

        run_op(3'd5, 32'h12345678, 32'h0, 1'b0, "mthi");
        check("mthi const hi", bus.hi, 32'h12345678);

        run_op(3'd1, 32'd3, 32'd7, 1'b1, "mult_interf");
        check("interf const hi", bus.hi, 32'd0);
        check("interf const lo", bus.lo, 32'd21);

        // Reset during the third busy cycle of mult 5*6.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd1;
        bus.num1  = 32'd5;
        bus.num2  = 32'd6;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst hi", bus.hi, 32'd0);
        check("midrst lo", bus.lo, 32'd0);
        repeat (10) @(negedge clk);
        check("midrst later busy", 32'(bus.busy), 32'd0);
        check("midrst later hi", bus.hi, 32'd0);
        check("midrst later lo", bus.lo, 32'd0);

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 9));
                3: b = 32'hFFFFFFFF - 32'($urandom_range(0, 9));
                default: ;
            endcase
            run_op(op, a, b, 1'b0, "rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the ALU in the execute stage of the MIPS datapath. It consumes the ALU operands (rs/rt register-file read results) and supports `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo`. It exposes HI/LO for `mfhi`/`mflo` through the write-back mux. A `busy` output lets the control/hazard logic stall dependent instructions while an operation is in flight.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`; must be ≥1.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`; must be ≥1.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `num1`  in  32  rs operand (dividend / multiplicand / mthi-mtlo source).
- `num2`  in  32  rt operand (divisor / multiplier).
- `op`  in  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op).
- `start`  in  1  qualifies `op` for one cycle.
- `busy`  out  1  high while a mult/div is in progress.
- `hi`  out  32  architectural HI register.
- `lo`  out  32  architectural LO register.

## Operation
- States: IDLE and BUSY. `busy` = (state == BUSY).
- IDLE, `start`=1, op 1–4: latch operands and op; compute the result into internal `res_hi`/`res_lo`; load the down-counter with N−1, where N = MULT_CYCLES or DIV_CYCLES; go to BUSY.
- BUSY: decrement the counter each cycle. When the counter is 0, write `hi`/`lo` from `res_hi`/`res_lo` and return to IDLE on the same edge.
- IDLE, `start`=1, op 5/6: `hi` (5) or `lo` (6) ← `num1` at the next edge. `busy` stays 0.
- IDLE, `start`=1, op 0/7: no effect.
- BUSY, `start`=1 with any op: ignored, including mthi/mtlo. The hazard logic guarantees this does not happen; the block must still not corrupt state.
- Multiply arithmetic:
  - `mult`: signed 32×32 → 64; `hi` = [63:32], `lo` = [31:0].
  - `multu`: unsigned 32×32 → 64, same split.
- Divide arithmetic:
  - `div` is signed. `lo` = quotient, truncated toward zero. `hi` = remainder, with the sign of the dividend.
  - `divu` is unsigned; `lo` = quotient, `hi` = remainder.
  - `div` of 0x80000000 by 0xFFFFFFFF gives `lo` = 0x80000000, `hi` = 0.
- Divisor = 0 (div/divu): the full busy period is still taken. At completion `hi`/`lo` keep their prior values.
- Operands are captured at start; `num1`/`num2` changes during BUSY have no effect.

## Timing
- Reset: `busy` = 0, `hi` = 0, `lo` = 0, state IDLE, counter 0. Reset takes priority over all other inputs. A reset during BUSY cancels the operation, and no HI/LO update follows.
- `start` sampled at the edge ending cycle T (mult/div):
  - `busy` = 1 for cycles T+1 … T+N.
  - New `hi`/`lo` are visible from cycle T+N+1, the same cycle `busy` returns to 0.
- A back-to-back start is accepted in cycle T+N+1, the first cycle with `busy` = 0.
- mthi/mtlo sampled at edge ending T: new value visible in T+1. No busy cycle.
- `hi`/`lo` are registered outputs. During BUSY they hold the pre-operation values.

## Configuration
- `MDU_DIV_EN` defined: div/divu are implemented as specified above.
- `MDU_DIV_EN` undefined:
  - No divider logic is synthesized.
  - op 3/4 behave as op 0: no busy and no HI/LO change.
  - `DIV_CYCLES` is unused.

## Test plan
- Reset:
  - Assert `rst` for 2 cycles → `busy` = 0, `hi` = 0, `lo` = 0.
  - Then op 0 with `start` = 1 → no change.
- Multiply:
  - `mult` 0xFFFFFFFF × 0x00000002 → `busy` high exactly 5 cycles, then `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFFE.
  - `multu` of the same operands → `hi` = 0x00000001, `lo` = 0xFFFFFFFE.
- Divide (`MDU_DIV_EN` defined):
  - `div` 0xFFFFFFF9 (−7) / 2 → `busy` 10 cycles, then `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
  - `divu` 7 / 2 → `lo` = 3, `hi` = 1.
  - `div` 0x80000000 / 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0.
- Divide by zero and macro off:
  - Preload `hi` = 0x11, `lo` = 0x22 via mthi/mtlo; then `divu` x / 0 → `busy` 10 cycles, `hi`/`lo` remain 0x11/0x22.
  - With the macro undefined, `div` → `busy` never asserts.
- Busy interference:
  - `mthi` 0x12345678 in IDLE → `hi` = 0x12345678 next cycle.
  - During a mult busy period, assert `mtlo` and `mult` starts with new operands → both ignored; the result reflects the first operands only.
- Reset mid-operation: start `mult` 5×6, assert `rst` in the 3rd busy cycle → `busy` = 0, `hi` = `lo` = 0 on the next cycle, and there is no later update to 30.
